stream_fifo: RTL and testbench
==============================

STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, >= 1.
REQ-002 Parameter DEPTH, default 4096: storage words; power of two, >= 4; AW = log2(DEPTH).
REQ-003 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 Parameter AFULL_LEVEL, default DEPTH-4: almost_full asserts when size >= AFULL_LEVEL.
REQ-005 Parameter AEMPTY_LEVEL, default 4: almost_empty asserts when size <= AEMPTY_LEVEL.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low; released synchronously to clk by the system.
REQ-008 clear  input  1  synchronous flush; discards all contents.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 input_ready  input  1  write strobe.
REQ-011 request_output  input  1  read request (mode 0) or pop of the head word (mode 1).
REQ-012 data_out  output  WIDTH  read data.
REQ-013 output_valid  output  1  data_out holds a valid word.
REQ-014 size  output  AW+1  words held, 0..DEPTH.
REQ-015 empty, full, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Write accepted iff input_ready=1 and full=0; data_in is stored at the write pointer and the write pointer increments modulo 2*DEPTH.
REQ-018 input_ready=1 while full=1 is dropped, storage is unchanged, and overflow sets; this applies even when a read is accepted in the same cycle.
REQ-019 Read accepted iff request_output=1 and empty=0 (mode 0), or request_output=1 and output_valid=1 (mode 1).
REQ-020 request_output=1 with no accept sets underflow, with no other state change.
REQ-021 Mode 0: on an accepted read in cycle N, data_out = head word and output_valid=1 in cycle N+1; output_valid=0 in any cycle not following an accepted read; data_out holds its last value otherwise.
REQ-022 Mode 1: whenever size>0 the head word is on data_out with output_valid=1; an accepted pop presents the next word in the following cycle, or clears output_valid if none remains.
REQ-023 Mode 1, write into an empty FIFO in cycle N: output_valid=1 and data_out = that word in cycle N+1.
REQ-024 size counts all held words, including a word prefetched to the output register in mode 1; it changes by +1 for a write-only accept, -1 for a read-only accept, and 0 for both or neither.
REQ-025 Simultaneous accepted read and write at any occupancy, including size=1 in mode 1, loses no data and preserves order.
REQ-026 Flags are registered or derived from registered state only: empty = (size==0), full = (size==DEPTH), plus the almost_* thresholds in REQ-004/005.
REQ-027 Pointers wrap at DEPTH with no gap; writing 3*DEPTH words through the FIFO returns them in order.
REQ-028 clear=1 sets pointers and size to 0, clears output_valid, and takes priority over a same-cycle read or write (both ignored, no error flags set).
REQ-029 overflow and underflow stay set until clear or reset.
REQ-030 Storage is a single inferred simple dual-port block RAM: one write port, one synchronous read port.

Reset
REQ-031 While rst_n=0: size=0, empty=1, almost_empty=1, full=0, almost_full=0, output_valid=0, data_out=0, overflow=0, underflow=0, and pointers=0.
REQ-032 Reset asserted mid-operation discards all contents immediately; the first cycle after release behaves as a freshly reset FIFO.
REQ-033 RAM contents are not reset and are never observable before being written.

Verification
REQ-034 DEPTH=16, FWFT=0: write 0x01..0x10, then read 16 back-to-back -> full=1 after 16th write; data 0x01..0x10 each one cycle after its request; empty=1 at end; no error flags.
REQ-035 DEPTH=16: 17 writes -> 17th dropped, overflow=1, size=16; then 1 read on empty after draining -> underflow=1, data unchanged.
REQ-036 FWFT=1: single write 0xA5 at cycle N -> output_valid=1 and data_out=0xA5 at N+1 with no request; pop -> output_valid=0, empty=1.
REQ-037 Simultaneous read+write at size=0, 1, 8, 16 in both modes -> size per REQ-024, order preserved, at size=16 write dropped and overflow set.
REQ-038 Random traffic, 10,000 cycles, both modes, DEPTH=16 -> output matches a reference queue; flags match REQ-026 every cycle.
REQ-039 rst_n pulsed low for 1 cycle with size=9, and clear pulsed with size=5 -> all outputs per REQ-031 and REQ-028; the next write/read pair returns the new word.

Source files
------------

// File: rtl/stream_fifo_if.sv
// Stream FIFO bus: write side, read side and status.
// The FIFO takes the slave modport; the user side takes master.
interface stream_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] data_in;
  logic             input_ready;
  logic             request_output;
  logic [WIDTH-1:0] data_out;
  logic             output_valid;
  logic [AW:0]      size;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output data_in,
    output input_ready,
    output request_output,
    input  data_out,
    input  output_valid,
    input  size,
    input  empty,
    input  full,
    input  almost_full,
    input  almost_empty,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  data_in,
    input  input_ready,
    input  request_output,
    output data_out,
    output output_valid,
    output size,
    output empty,
    output full,
    output almost_full,
    output almost_empty,
    output overflow,
    output underflow
  );
endinterface

// File: rtl/stream_fifo.sv
// Stream FIFO on a simple dual-port RAM.
// Registered-read or first-word-fall-through output via FWFT.
module stream_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4096,
  parameter int FWFT         = 0,
  parameter int AFULL_LEVEL  = DEPTH - 4,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  stream_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] mem_q;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_next;
  logic [AW:0]      count;
  logic [AW-1:0]    rd_addr;
  logic             rd_en;
  logic             wr_acc;
  logic             rd_acc;
  logic             is_empty;
  logic             is_full;
  logic             ovf_q;
  logic             udf_q;

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);

  assign bus.size         = count;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_full  = (int'(count) >= AFULL_LEVEL);
  assign bus.almost_empty = (int'(count) <= AEMPTY_LEVEL);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  // Accept decode; clear masks both sides.
  always_comb begin
    wr_acc  = bus.input_ready & ~is_full & ~clear;
    rd_acc  = bus.request_output & ~is_empty & ~clear;
    rd_next = rd_acc ? rd_ptr + ONE : rd_ptr;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      rd_ptr <= rd_next;
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a dropped write counts even alongside a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (clear) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.input_ready & is_full) ovf_q <= 1'b1;
      if (bus.request_output & is_empty) udf_q <= 1'b1;
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= bus.data_in;
  end

  // RAM synchronous read port; contents and output are not reset.
  always_ff @(posedge clk) begin
    if (rd_en) mem_q <= mem[rd_addr];
  end

  if (FWFT == 0) begin : g_reg
    logic ov_q;
    logic primed_q;

    assign rd_en   = rd_acc;
    assign rd_addr = rd_ptr[AW-1:0];

    // Valid follows an accepted read; primed hides unread RAM output.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ov_q     <= 1'b0;
        primed_q <= 1'b0;
      end else begin
        ov_q     <= rd_acc;
        primed_q <= primed_q | rd_acc;
      end
    end

    assign bus.output_valid = ov_q;
    assign bus.data_out     = primed_q ? mem_q : '0;
  end else begin : g_fwft
    logic             byp_q;
    logic [WIDTH-1:0] byp_d;

    assign rd_en   = 1'b1;
    assign rd_addr = rd_next[AW-1:0];

    // The RAM reads old data when the next head is being written,
    // so that word is captured straight from data_in instead.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        byp_q <= 1'b0;
        byp_d <= '0;
      end else begin
        byp_q <= wr_acc & (wr_ptr[AW-1:0] == rd_next[AW-1:0]);
        if (wr_acc) byp_d <= bus.data_in;
      end
    end

    assign bus.output_valid = ~is_empty;
    assign bus.data_out     = is_empty ? '0 : (byp_q ? byp_d : mem_q);
  end
endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: registered and FWFT instances, DEPTH 16,
// one shared stimulus checked against a reference queue.
module tb_stream_fifo;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;

  stream_fifo_if #(.WIDTH(8), .DEPTH(16)) f0 ();
  stream_fifo_if #(.WIDTH(8), .DEPTH(16)) f1 ();

  stream_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(f0)
  );
  stream_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(f1)
  );

  always #5 clk = ~clk;

  logic [7:0] mq[$];
  logic [7:0] exp0[$];
  logic       m_ov0 = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [7:0] m_last0 = 8'h00;
  int         lv[4] = '{0, 1, 8, 16};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic wr, input logic [7:0] d,
                       input logic rd);
    f0.input_ready    = wr;
    f0.data_in        = d;
    f0.request_output = rd;
    f1.input_ready    = wr;
    f1.data_in        = d;
    f1.request_output = rd;
  endtask

  task automatic observe();
    int n;
    n = mq.size();
    chk("size0", 32'(f0.size), n);
    chk("size1", 32'(f1.size), n);
    chk("empty0", 32'(f0.empty), 32'(n == 0));
    chk("empty1", 32'(f1.empty), 32'(n == 0));
    chk("full0", 32'(f0.full), 32'(n == 16));
    chk("full1", 32'(f1.full), 32'(n == 16));
    chk("afull0", 32'(f0.almost_full), 32'(n >= 12));
    chk("afull1", 32'(f1.almost_full), 32'(n >= 12));
    chk("aempty0", 32'(f0.almost_empty), 32'(n <= 4));
    chk("aempty1", 32'(f1.almost_empty), 32'(n <= 4));
    chk("ovf0", 32'(f0.overflow), 32'(m_ovf));
    chk("ovf1", 32'(f1.overflow), 32'(m_ovf));
    chk("udf0", 32'(f0.underflow), 32'(m_udf));
    chk("udf1", 32'(f1.underflow), 32'(m_udf));
    chk("ov0", 32'(f0.output_valid), 32'(m_ov0));
    if (m_ov0 && exp0.size() != 0) m_last0 = exp0.pop_front();
    chk("dout0", 32'(f0.data_out), 32'(m_last0));
    chk("ov1", 32'(f1.output_valid), 32'(n != 0));
    if (n != 0) chk("dout1", 32'(f1.data_out), 32'(mq[0]));
  endtask

  task automatic cyc(input logic wr, input logic [7:0] d,
                     input logic rd, input logic clr);
    logic wa;
    logic ra;
    drive(wr, d, rd);
    clear = clr;
    wa = wr && (mq.size() != 16) && !clr;
    ra = rd && (mq.size() != 0) && !clr;
    if (clr) begin
      mq.delete();
      exp0.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr && mq.size() == 16) m_ovf = 1'b1;
      if (rd && mq.size() == 0) m_udf = 1'b1;
      if (ra) exp0.push_back(mq.pop_front());
      if (wa) mq.push_back(d);
    end
    m_ov0 = ra;
    @(posedge clk);
    @(negedge clk);
    observe();
  endtask

  task automatic pulse_reset();
    drive(1'b0, 8'h00, 1'b0);
    clear = 1'b0;
    rst_n = 1'b0;
    #1;
    mq.delete();
    exp0.delete();
    m_ov0   = 1'b0;
    m_last0 = 8'h00;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    observe();
    chk("rst_dout1", 32'(f1.data_out), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    observe();
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    pulse_reset();

    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 1; i <= 17; i++) cyc(1'b1, 8'(i + 32), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);

    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    foreach (lv[k]) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < lv[k]; i++) cyc(1'b1, 8'(i + 64), 1'b0, 1'b0);
      cyc(1'b1, 8'(128 + lv[k]), 1'b1, 1'b0);
      cyc(1'b1, 8'(160 + lv[k]), 1'b1, 1'b0);
      for (int i = 0; i <= lv[k]; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(i + 200), 1'b0, 1'b0);
    pulse_reset();
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i + 220), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    cyc(1'b1, 8'h6B, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    for (int p = 0; p < 20; p++) begin
      int pw;
      int pr;
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 500; i++) begin
        cyc($urandom_range(0, 99) < pw, 8'($urandom),
            $urandom_range(0, 99) < pr, $urandom_range(0, 499) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
